// File: rtl/vdb_input_pkg.sv
// Shared definitions for the DE10-Lite input conditioner: idle level of the
// active-low push-buttons and the debounce-window length calculation.
package vdb_input_pkg;

    // Raw push-button pin level when the button is not pressed.
    localparam logic KEY_IDLE = 1'b1;

    // Number of CLK_50 cycles in a debounce window of 'ms' milliseconds.
    function automatic int db_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/vdb_debounce.sv
// One-bit input conditioner: 2-FF synchroniser, debounce filter, registered
// level and rise/fall pulses.
// The filter is built only when VDB_DEBOUNCE_EN is defined; otherwise the
// stable value simply follows the synchroniser output every cycle.
module vdb_debounce
    import vdb_input_pkg::*;
#(
    parameter int   DB_CYC  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic stable_p2;
    logic level_p3;
    logic rise_p3;
    logic fall_p3;

    // Stage 0/1: two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

`ifdef VDB_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYC < 1) ? 1 : $clog2(DB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DB_CYC < 1) ? 0 : DB_CYC - 1);

    if (DB_CYC < 1) begin : g_bad_window
        $error("vdb_debounce: debounce window DB_CYC must be at least 1 cycle");
    end

    logic [CNT_W-1:0] cnt_p2;

    // Stage 2: accept a new level only after it has persisted for DB_CYC cycles;
    // any return to the current stable level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_p2 <= RST_VAL;
            cnt_p2    <= '0;
        end else if (sync_p1 == stable_p2) begin
            cnt_p2    <= '0;
        end else if (cnt_p2 == CNT_LAST) begin
            stable_p2 <= sync_p1;
            cnt_p2    <= '0;
        end else begin
            cnt_p2    <= cnt_p2 + 1'b1;
        end
    end
`else
    // Stage 2: no filtering, the stable value tracks the synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_p2 <= RST_VAL;
        end else begin
            stable_p2 <= sync_p1;
        end
    end
`endif

    // Stage 3: registered level plus one-cycle pulses on each stable transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_p3 <= RST_VAL;
            rise_p3  <= 1'b0;
            fall_p3  <= 1'b0;
        end else begin
            level_p3 <= stable_p2;
            rise_p3  <= stable_p2 & ~level_p3;
            fall_p3  <= ~stable_p2 & level_p3;
        end
    end

    assign level = level_p3;
    assign rise  = rise_p3;
    assign fall  = fall_p3;

endmodule

// File: rtl/de10lite_input_conditioner.sv
// DE10-Lite KEY/SW conditioner placed between the board pins and the design
// core. Every bit is synchronised, debounced and turned into level and event
// outputs independently. Push-buttons are active-low at the pins and are
// presented active-high (1 = pressed) to user logic.
// Build option: define VDB_DEBOUNCE_EN to enable the debounce filter; without
// it the inputs are only synchronised (fast simulation builds).
module de10lite_input_conditioner
    import vdb_input_pkg::*;
#(
    parameter int N_KEY       = 2,
    parameter int N_SW        = 10,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 5
) (
    input  logic             CLK_50,
    input  logic             RST_N,
    input  logic [N_KEY-1:0] KEY,
    input  logic [N_SW-1:0]  SW,
    output logic [N_KEY-1:0] key_o,
    output logic [N_KEY-1:0] key_press_o,
    output logic [N_KEY-1:0] key_release_o,
    output logic [N_SW-1:0]  sw_o,
    output logic [N_SW-1:0]  sw_change_o
);

    localparam int DB_CYC = db_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_rise;
    logic [N_KEY-1:0] key_fall;
    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;

    // Buttons idle high; a press is a falling edge of the pin-level value.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        vdb_debounce #(
            .DB_CYC  (DB_CYC),
            .RST_VAL (KEY_IDLE)
        ) u_key (
            .clk   (CLK_50),
            .rst_n (RST_N),
            .pin   (KEY[i]),
            .level (key_level[i]),
            .rise  (key_rise[i]),
            .fall  (key_fall[i])
        );
    end

    // Switches are active-high and reset to off.
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        vdb_debounce #(
            .DB_CYC  (DB_CYC),
            .RST_VAL (1'b0)
        ) u_sw (
            .clk   (CLK_50),
            .rst_n (RST_N),
            .pin   (SW[i]),
            .level (sw_o[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    assign key_o         = ~key_level;
    assign key_press_o   = key_fall;
    assign key_release_o = key_rise;
    assign sw_change_o   = sw_rise | sw_fall;

endmodule
